// File: rtl/lagarto_fp_norm_if.sv
// Handshake and payload bundle for the lagarto_fp_norm normalization stage.
//
// Signals
//   in_valid_i / in_ready_o    : input beat handshake
//   mant_i, exp_i              : unnormalized mantissa and signed biased exponent
//   lzc_cnt_i, lzc_nz_i        : leading-zero count and nonzero flag of mant_i
//   out_valid_o / out_ready_i  : output beat handshake
//   mant_o, exp_o              : left-justified mantissa and adjusted exponent
//   zero_o, denorm_o, inexact_o: result classification flags
//
// Modports
//   slave  : the normalization stage itself
//   master : the surrounding logic (producer of inputs, consumer of outputs)
interface lagarto_fp_norm_if #(
    parameter int EXP_W = 13
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [63:0]             mant_i;
    logic signed [EXP_W-1:0] exp_i;
    logic [5:0]              lzc_cnt_i;
    logic                    lzc_nz_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [63:0]             mant_o;
    logic signed [EXP_W-1:0] exp_o;
    logic                    zero_o;
    logic                    denorm_o;
    logic                    inexact_o;

    modport slave (
        input  in_valid_i, mant_i, exp_i, lzc_cnt_i, lzc_nz_i, out_ready_i,
        output in_ready_o, out_valid_o, mant_o, exp_o, zero_o, denorm_o, inexact_o
    );

    modport master (
        output in_valid_i, mant_i, exp_i, lzc_cnt_i, lzc_nz_i, out_ready_i,
        input  in_ready_o, out_valid_o, mant_o, exp_o, zero_o, denorm_o, inexact_o
    );
endinterface

// File: rtl/lagarto_fp_norm.sv
// lagarto_fp_norm: two-stage normalization stage fed by the 64-bit LZC.
//
// Stage 1 chooses the left-shift amount from the exponent and leading-zero
// count, clamping so the exponent never drops below EMIN (subnormal results).
// Stage 2 performs the shift and presents the beat to the rounding/packing
// stage over a valid/ready handshake.
//
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset (drops all in-flight beats)
//   bus  : lagarto_fp_norm_if.slave, handshake + payload (see interface file)
//
// Parameters
//   EXP_W : width of the two's complement biased exponent
//   EMIN  : smallest normal biased exponent
//
// Configuration macro
//   FP_NORM_ROUND_EN : when defined, stage 2 also rounds the shifted mantissa
//                      to 53 bits (round-to-nearest-even) and drives inexact_o.
//                      When undefined, mant_o is the raw shift and inexact_o=0.
module lagarto_fp_norm #(
    parameter int EXP_W = 13,
    parameter int EMIN  = 1
) (
    input logic             clk,
    input logic             rst,
    lagarto_fp_norm_if.slave bus
);

    localparam logic signed [EXP_W:0]   EMIN_X = (EXP_W+1)'(EMIN);
    localparam logic signed [EXP_W-1:0] EMIN_E = EXP_W'(EMIN);

    // Handshake: stage 2 can take a beat when empty or draining this cycle.
    logic adv_p2;
    logic in_ready;
    logic vld_p1, vld_p2;

    assign adv_p2        = ~vld_p2 | bus.out_ready_i;
    assign in_ready      = ~vld_p1 | adv_p2;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_p2;

    // One extra bit so exp_i - lzc_cnt_i cannot wrap around.
    logic signed [EXP_W:0] exp_ext, lzc_ext, d_ext, ovr_ext;
    logic [5:0]            sh_c;
    logic signed [EXP_W-1:0] exp_c;
    logic                  zero_c, denorm_c;

    assign exp_ext = {bus.exp_i[EXP_W-1], bus.exp_i};
    assign lzc_ext = {{(EXP_W-5){1'b0}}, bus.lzc_cnt_i};
    assign d_ext   = exp_ext - lzc_ext;
    assign ovr_ext = exp_ext - EMIN_X;

    always_comb begin
        sh_c     = '0;
        exp_c    = '0;
        zero_c   = 1'b0;
        denorm_c = 1'b0;
        if (!bus.lzc_nz_i) begin
            zero_c = 1'b1;
        end else if (d_ext >= EMIN_X) begin
            sh_c  = bus.lzc_cnt_i;
            exp_c = d_ext[EXP_W-1:0];
        end else if (exp_ext > EMIN_X) begin
            // Here exp_i - EMIN < lzc_cnt_i <= 63, so the low 6 bits are exact.
            sh_c     = ovr_ext[5:0];
            denorm_c = 1'b1;
        end else begin
            denorm_c = 1'b1;
        end
    end

    // ---- Stage 1 registers ----
    logic [63:0]             mant_p1;
    logic [5:0]              sh_p1;
    logic signed [EXP_W-1:0] exp_p1;
    logic                    zero_p1, denorm_p1;

    always_ff @(posedge clk) begin
        if (rst)           vld_p1 <= 1'b0;
        else if (in_ready) vld_p1 <= bus.in_valid_i;
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid_i && in_ready) begin
            mant_p1   <= bus.mant_i;
            sh_p1     <= sh_c;
            exp_p1    <= exp_c;
            zero_p1   <= zero_c;
            denorm_p1 <= denorm_c;
        end
    end

    logic [63:0] shifted;
    assign shifted = mant_p1 << sh_p1;

`ifdef FP_NORM_ROUND_EN
    // Round to 53 bits (63:11), nearest-even. Returns {carry, inexact, mant}.
    function automatic logic [65:0] round_rne(input logic [63:0] m);
        logic        guard, sticky, inc;
        logic [53:0] up;
        logic [63:0] res;
        guard  = m[10];
        sticky = |m[9:0];
        inc    = guard & (sticky | m[11]);
        up     = {1'b0, m[63:11]} + {53'b0, inc};
        res    = up[53] ? 64'h8000_0000_0000_0000 : {up[52:0], 11'b0};
        return {up[53], guard | sticky, res};
    endfunction
`endif

    logic [63:0]             mant_c2;
    logic signed [EXP_W-1:0] exp_c2;
    logic                    denorm_c2, inexact_c2;

    always_comb begin
        mant_c2    = shifted;
        exp_c2     = exp_p1;
        denorm_c2  = denorm_p1;
        inexact_c2 = 1'b0;
`ifdef FP_NORM_ROUND_EN
        begin
            logic carry;
            {carry, inexact_c2, mant_c2} = round_rne(shifted);
            // A subnormal that rounds up into bit 63 becomes the smallest normal.
            if (denorm_p1 && (carry || (!shifted[63] && mant_c2[63]))) begin
                denorm_c2 = 1'b0;
                exp_c2    = EMIN_E;
            end else if (carry) begin
                exp_c2 = exp_p1 + EXP_W'(1);
            end
        end
`endif
    end

    // ---- Stage 2 registers ----
    logic [63:0]             mant_p2;
    logic signed [EXP_W-1:0] exp_p2;
    logic                    zero_p2, denorm_p2, inexact_p2;

    always_ff @(posedge clk) begin
        if (rst)         vld_p2 <= 1'b0;
        else if (adv_p2) vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mant_p2    <= '0;
            exp_p2     <= '0;
            zero_p2    <= 1'b0;
            denorm_p2  <= 1'b0;
            inexact_p2 <= 1'b0;
        end else if (vld_p1 && adv_p2) begin
            mant_p2    <= mant_c2;
            exp_p2     <= exp_c2;
            zero_p2    <= zero_p1;
            denorm_p2  <= denorm_c2;
            inexact_p2 <= inexact_c2;
        end
    end

    assign bus.mant_o    = mant_p2;
    assign bus.exp_o     = exp_p2;
    assign bus.zero_o    = zero_p2;
    assign bus.denorm_o  = denorm_p2;
    assign bus.inexact_o = inexact_p2;

endmodule

// File: tb/tb_lagarto_fp_norm.sv
// Scoreboard testbench for lagarto_fp_norm: directed vectors push their
// hand-computed results into a queue; a monitor pops and compares each
// accepted output beat.
module tb_lagarto_fp_norm;

    localparam int EXP_W = 13;
`ifdef FP_NORM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [63:0]             mant;
        logic signed [EXP_W-1:0] exp;
        logic                    zero;
        logic                    denorm;
        logic                    inexact;
        int                      id;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lagarto_fp_norm_if #(.EXP_W(EXP_W)) bus ();

    lagarto_fp_norm #(.EXP_W(EXP_W), .EMIN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_id  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: compare every accepted output beat against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got mant=%h exp=%0d, expected no beat",
                         bus.mant_o, bus.exp_o);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (bus.mant_o !== e.mant || bus.exp_o !== e.exp || bus.zero_o !== e.zero ||
                    bus.denorm_o !== e.denorm || bus.inexact_o !== e.inexact) begin
                    n_bad++;
                    $display("FAIL beat%0d: got mant=%h exp=%0d z=%b d=%b i=%b, expected mant=%h exp=%0d z=%b d=%b i=%b",
                             e.id, bus.mant_o, bus.exp_o, bus.zero_o, bus.denorm_o, bus.inexact_o,
                             e.mant, e.exp, e.zero, e.denorm, e.inexact);
                end
            end
        end
    end

    // Drive one beat and wait (bounded) for its acceptance. Call at posedge+1.
    task automatic send(input logic [63:0] m, input int e, input int l, input logic nz,
                        input logic [63:0] em, input int ee, input logic ez,
                        input logic ed, input logic ei);
        beat_t b;
        bit    done;
        b.mant = em; b.exp = EXP_W'(ee); b.zero = ez; b.denorm = ed; b.inexact = ei;
        b.id   = n_id++;
        bus.mant_i     = m;
        bus.exp_i      = EXP_W'(e);
        bus.lzc_cnt_i  = 6'(l);
        bus.lzc_nz_i   = nz;
        bus.in_valid_i = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                sb.push_back(b);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout beat%0d: got in_ready=0, expected acceptance", b.id);
        end
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.mant_i      = '0;
        bus.exp_i       = '0;
        bus.lzc_cnt_i   = '0;
        bus.lzc_nz_i    = 1'b0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("rst_mant",      bus.mant_o,           64'd0);
        check("rst_exp",       64'(bus.exp_o),       64'd0);
        check("rst_flags",     64'({bus.zero_o, bus.denorm_o, bus.inexact_o}), 64'd0);

        // Latency: normal shift, output valid exactly 2 cycles after acceptance
        bus.out_ready_i = 1'b1;
        send(64'h0000_0000_0001_0000, 100, 47, 1, 64'h8000_0000_0000_0000, 53, 0, 0, 0);
        idle();
        @(negedge clk);
        check("latency_c1_valid", 64'(bus.out_valid_o), 64'd0);
        @(negedge clk);
        check("latency_c2_valid", 64'(bus.out_valid_o), 64'd1);
        @(posedge clk); #1;

        // Back-to-back directed vectors at full throughput
        send(64'd0, 40, 0, 0, 64'd0, 0, 1, 0, 0);                                   // zero
        send(64'h0000_0000_0000_0100, 5, 55, 1, 64'h0000_0000_0000_1000, 0, 0, 1, 0); // clamp sh=4
        send(64'h0000_0000_0000_0001, 1, 63, 1,
             RND ? 64'd0 : 64'd1, 0, 0, 1, RND);                                    // exp_i == EMIN
        send(64'h00FF_0000_0000_0000, 9, 8, 1, 64'hFF00_0000_0000_0000, 1, 0, 0, 0); // d == EMIN
        send(64'h00FF_0000_0000_0000, 8, 8, 1, 64'h7F80_0000_0000_0000, 0, 0, 1, 0); // d == EMIN-1
        send(64'h8000_0000_0000_0000, -5, 0, 1, 64'h8000_0000_0000_0000, 0, 0, 1, 0); // negative exp
        send(64'h0000_0000_0000_0001, 4095, 63, 1, 64'h8000_0000_0000_0000, 4032, 0, 0, 0); // sh=63
        send(64'h0000_0000_0000_0001, -4096, 63, 1,
             RND ? 64'd0 : 64'd1, 0, 0, 1, RND);                                    // no wrap
        send(64'h0123_4567_89AB_CDEF, 1000, 7, 1,
             RND ? 64'h91A2_B3C4_D5E6_F800 : 64'h91A2_B3C4_D5E6_F780, 993, 0, 0, RND);
        send(64'hFFFF_FFFF_FFFF_FC00, 10, 0, 1,
             RND ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FC00,
             RND ? 11 : 10, 0, 0, RND);                                             // round carry
        send(64'h8000_0000_0000_0400, 50, 0, 1,
             RND ? 64'h8000_0000_0000_0000 : 64'h8000_0000_0000_0400, 50, 0, 0, RND); // tie to even
        send(64'h7FFF_FFFF_FFFF_FC00, 1, 1, 1,
             RND ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FC00,
             RND ? 1 : 0, 0, !RND, RND);                                            // subnormal rounds up
        idle();
        cycles(4);

        // Back-pressure: two beats fill the pipe, third must wait
        bus.out_ready_i = 1'b0;
        send(64'h0000_0000_0000_8000, 60, 48, 1, 64'h8000_0000_0000_0000, 12, 0, 0, 0);
        send(64'h0000_0000_4000_0000, 60, 33, 1, 64'h8000_0000_0000_0000, 27, 0, 0, 0);
        bus.mant_i = 64'h1; bus.in_valid_i = 1'b1;
        check("bp_in_ready_full", 64'(bus.in_ready_o), 64'd0);
        cycles(1);
        check("bp_in_ready_hold", 64'(bus.in_ready_o), 64'd0);
        check("bp_payload_stable", bus.mant_o, 64'h8000_0000_0000_0000);
        check("bp_exp_stable", 64'(bus.exp_o), 64'd12);
        cycles(1);
        bus.out_ready_i = 1'b1;
        send(64'h0000_0000_0000_0002, 70, 62, 1, 64'h8000_0000_0000_0000, 8, 0, 0, 0);
        send(64'h0000_0000_0000_0300, 70, 54, 1, 64'hC000_0000_0000_0000, 16, 0, 0, 0);
        idle();
        for (int t = 0; t < 50 && sb.size() != 0; t++) cycles(1);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset mid-stream with both stages full
        bus.out_ready_i = 1'b0;
        send(64'h0000_0000_0000_0F00, 30, 52, 1, 64'hF000_0000_0000_0000, 0, 0, 0, 0);
        send(64'h0000_0000_0000_00F0, 30, 56, 1, 64'hF000_0000_0000_0000, 0, 0, 0, 0);
        idle();
        rst = 1'b1;
        sb.delete();
        cycles(1);
        check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("midrst_mant",      bus.mant_o,           64'd0);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        cycles(8);

        // Pipeline still works after the flush
        send(64'h0000_0000_0000_0100, 5, 55, 1, 64'h0000_0000_0000_1000, 0, 0, 1, 0);
        idle();
        for (int t = 0; t < 20 && sb.size() != 0; t++) cycles(1);
        check("final_drained", 64'(sb.size()), 64'd0);
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lagarto_fp_norm.md
Name: lagarto_fp_norm

Overview:
- Normalization stage directly downstream of the FPU 64-bit leading-zero counter.
- Takes an unnormalized 64-bit mantissa, its signed biased exponent and the LZC result (count, nonzero flag).
- Produces a left-justified mantissa with the adjusted exponent, clamping to the subnormal range when the exponent would drop below 1.
- Two-stage valid/ready pipeline; feeds the rounding/packing stage.

Parameters:
- EXP_W, 13, width of signed biased exponent (two's complement).
- EMIN, 1, smallest normal biased exponent; results below it are denormalized.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  stage can accept an input beat.
- mant_i  in  64  unnormalized mantissa.
- exp_i  in  EXP_W  signed biased exponent of mant_i (value of bit 63 position).
- lzc_cnt_i  in  6  leading-zero count of mant_i (0..63).
- lzc_nz_i  in  1  1 = mant_i nonzero; 0 = all zero, lzc_cnt_i ignored.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer accepts the output beat.
- mant_o  out  64  shifted mantissa.
- exp_o  out  EXP_W  adjusted exponent.
- zero_o  out  1  result is exactly zero.
- denorm_o  out  1  shift was limited by EMIN (subnormal result).
- inexact_o  out  1  rounding discarded nonzero bits (0 when FP_NORM_ROUND_EN is not defined).

Behaviour:
- Reset: out_valid_o=0, mant_o=0, exp_o=0, zero_o=0, denorm_o=0, inexact_o=0. Both stage valids clear. in_ready_o=1 on the first cycle after reset.
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- Handshake: a beat transfers on in_valid_i & in_ready_o, and on out_valid_o & out_ready_i.
  - Payload of a pending out_valid_o beat stays stable until accepted.
  - in_ready_o = ~s1_valid | s1_advance, where s1_advance = ~s2_valid | out_ready_i.
  - in_ready_o is combinational from out_ready_i.
  - Full throughput: 1 beat/cycle while out_ready_i=1.
- Latency: 2 cycles from input acceptance to out_valid_o, with no stall.
- Stage 1 (registered on acceptance):
  - Computes the shift amount sh from d = exp_i - lzc_cnt_i, sign-extended to EXP_W+1 bits so it cannot wrap.
  - If lzc_nz_i=0: sh=0, zero=1, denorm=0, exp=0.
  - Else if d >= EMIN: sh=lzc_cnt_i, exp=d, denorm=0.
  - Else if exp_i > EMIN: sh=exp_i-EMIN, exp=0, denorm=1.
  - Else (exp_i <= EMIN): sh=0, exp=0, denorm=1.
  - sh never exceeds 63.
- Stage 2 (registered on s1_advance):
  - mant_o = mant << sh; zeros shift in at the LSB.
  - Flags and exp_o pass through with the beat.
- Stall: with out_valid_o=1 and out_ready_i=0, both stages hold. in_ready_o=0 once stage 1 is also full.
- Simultaneous input accept and output accept in the same cycle: both stages advance, with no bubble and no loss.

Optional Feature:
- Macro FP_NORM_ROUND_EN.
- When defined:
  - Stage 2 additionally rounds the shifted mantissa to 53 bits (bits 63:11) with round-to-nearest-even.
    - Guard = bit 10; sticky = OR of bits 9:0.
    - Increment when guard & (sticky | bit 11).
  - inexact_o = guard | sticky.
  - Carry-out of the round sets mant_o = 64'h8000_0000_0000_0000 and exp_o+1. If the beat was denorm and rounding reaches bit 63, denorm_o clears and exp_o=EMIN.
  - Bits 10:0 of mant_o = 0.
  - Latency is unchanged.
- When not defined: mant_o is the raw shift, inexact_o is tied 0, and no rounding logic is present.

Test Plan:
- Normal shift: mant_i=64'h0000_0000_0001_0000, exp_i=100, lzc_cnt_i=47, lzc_nz_i=1, out_ready_i=1 -> after 2 cycles: mant_o=64'h8000_0000_0000_0000, exp_o=53, zero_o=0, denorm_o=0.
- Zero input: mant_i=0, lzc_nz_i=0, exp_i=40 -> mant_o=0, exp_o=0, zero_o=1, denorm_o=0.
- Subnormal clamp: mant_i=64'h0000_0000_0000_0100, exp_i=5, lzc_cnt_i=55 -> sh=4, mant_o=64'h0000_0000_0000_1000, exp_o=0, denorm_o=1.
- Back-pressure: stream 4 beats while out_ready_i=0 for 3 cycles, then 1 -> in_ready_o=0 after 2 beats are held; all 4 beats emerge in order; no beat is duplicated or dropped.
- Reset mid-stream: assert rst with both stages valid -> next cycle out_valid_o=0 and in_ready_o=1; the held beats never appear.
- Rounding, FP_NORM_ROUND_EN only: mant_i=64'hFFFF_FFFF_FFFF_FC00, exp_i=10, lzc_cnt_i=0 -> mant_o=64'h8000_0000_0000_0000, exp_o=11, inexact_o=1.
